// File: rtl/seven_seg_mux.sv
// Time-multiplexed N-digit seven-segment driver with shadowed patterns and enable-aware scan.
// Optional per-slot anode dimming is compiled in with SEVEN_SEG_BRIGHTNESS_EN.
module seven_seg_mux #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEG_W      = 7,
  parameter int unsigned DIV        = 17500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_DIGITS*SEG_W-1:0]   digits_in,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         digit_en,
`ifdef SEVEN_SEG_BRIGHTNESS_EN
  input  logic [3:0]                    duty,
`endif
  output logic [SEG_W-1:0]              segment,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          sig
);

  localparam int unsigned CBITS = $clog2(DIV + 1);
  localparam int unsigned IDXW  = $clog2(NUM_DIGITS);

  logic [CBITS-1:0]            cnt_q, cnt_d;
  logic                        sig_q, sig_d;
  logic [SEG_W-1:0]            segment_q, segment_d;
  logic [NUM_DIGITS-1:0]       anode_q, anode_d;
  logic [IDXW-1:0]             digit_idx_q, digit_idx_d;
  logic [NUM_DIGITS*SEG_W-1:0] shadow_q, shadow_d;

  logic            tick;
  logic            hit;
  logic [IDXW-1:0] next_idx;
  logic [31:0]     pos;

  assign tick = (cnt_q >= CBITS'(DIV));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CBITS'(1);
  end

  // Circular search starting one past the current digit; offset NUM_DIGITS lands on the
  // current digit itself, so a lone enabled digit is reselected.
  always_comb begin
    hit      = 1'b0;
    next_idx = digit_idx_q;
    pos      = '0;
    for (int unsigned o = 1; o <= NUM_DIGITS; o++) begin
      pos = (32'(digit_idx_q) + o) % NUM_DIGITS;
      if (!hit && digit_en[pos[IDXW-1:0]]) begin
        hit      = 1'b1;
        next_idx = pos[IDXW-1:0];
      end
    end
  end

  always_comb begin
    sig_d       = 1'b0;
    segment_d   = segment_q;
    anode_d     = anode_q;
    digit_idx_d = digit_idx_q;
    if (tick) begin
      sig_d = 1'b1;
      if (hit) begin
        digit_idx_d = next_idx;
        anode_d     = NUM_DIGITS'(1) << next_idx;
        // Reads the pre-load shadow, so a coincident load shows up only at the next tick.
        segment_d   = shadow_q[32'(next_idx)*SEG_W +: SEG_W];
      end else begin
        anode_d   = '0;
        segment_d = '0;
      end
    end
  end

  always_comb begin
    shadow_d = load ? digits_in : shadow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sig_q       <= 1'b0;
      segment_q   <= '0;
      anode_q     <= '0;
      digit_idx_q <= IDXW'(NUM_DIGITS - 1);
      shadow_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      segment_q   <= segment_d;
      anode_q     <= anode_d;
      digit_idx_q <= digit_idx_d;
      shadow_q    <= shadow_d;
    end
  end

`ifdef SEVEN_SEG_BRIGHTNESS_EN
  localparam int unsigned TW = CBITS + 5;

  logic [TW-1:0] thresh;

  // duty=15 yields thresh=DIV+1, which cnt never reaches: full-slot brightness.
  always_comb begin
    thresh = ((TW'(duty) + TW'(1)) * TW'(DIV + 1)) >> 4;
  end

  assign anode = (TW'(cnt_q) >= thresh) ? '0 : anode_q;
`else
  assign anode = anode_q;
`endif

  assign segment   = segment_q;
  assign digit_idx = digit_idx_q;
  assign sig       = sig_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed, scoreboard-driven bench for seven_seg_mux with DIV=3, NUM_DIGITS=4, SEG_W=7.
module tb_seven_seg_mux;

  localparam int unsigned ND  = 4;
  localparam int unsigned SW  = 7;
  localparam int unsigned DV  = 3;
  localparam int          BUDGET = 20;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [SW-1:0] seg;
    logic [1:0]    idx;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [ND*SW-1:0] digits_in;
  logic           load;
  logic [ND-1:0]  digit_en;
  logic [SW-1:0]  segment;
  logic [ND-1:0]  anode;
  logic [1:0]     digit_idx;
  logic           sig;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
  logic [3:0]     duty;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  seven_seg_mux #(
    .NUM_DIGITS(ND),
    .SEG_W     (SW),
    .DIV       (DV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits_in(digits_in),
    .load     (load),
    .digit_en (digit_en),
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    .duty     (duty),
`endif
    .segment  (segment),
    .anode    (anode),
    .digit_idx(digit_idx),
    .sig      (sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [ND-1:0] an, input logic [SW-1:0] seg, input logic [1:0] idx);
    exp_t e;
    e.an  = an;
    e.seg = seg;
    e.idx = idx;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the refresh tick, checks the gap, then pops and compares one entry.
  task automatic wait_tick(input string tag, input int exp_gap);
    int   n;
    bit   seen;
    exp_t e;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (sig === 1'b1) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen && exp_gap != 0) chk({tag, "_gap"}, 32'(n), 32'(exp_gap));
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_anode"},   32'(anode),     32'(e.an));
      chk({tag, "_segment"}, 32'(segment),   32'(e.seg));
      chk({tag, "_idx"},     32'(digit_idx), 32'(e.idx));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    digit_en  = '0;
    digits_in = '0;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    duty      = 4'd15;
`endif
    #12;
    chk("rst_segment", 32'(segment),   32'h0);
    chk("rst_anode",   32'(anode),     32'h0);
    chk("rst_sig",     32'(sig),       32'h0);
    chk("rst_idx",     32'(digit_idx), 32'd3);

    // All four digits enabled, patterns loaded on the first edge after release.
    @(negedge clk);
    rst_n     = 1'b1;
    load      = 1'b1;
    digits_in = {7'h08, 7'h04, 7'h02, 7'h01};
    digit_en  = 4'b1111;
    push(4'b0001, 7'h01, 2'd0);
    push(4'b0010, 7'h02, 2'd1);
    push(4'b0100, 7'h04, 2'd2);
    push(4'b1000, 7'h08, 2'd3);
    push(4'b0001, 7'h01, 2'd0);
    wait_tick("all_t0", 4);
    load = 1'b0;
    for (int i = 0; i < 4; i++) wait_tick("all_tn", 4);

    // Sparse enable: only digits 1 and 3.
    digit_en = 4'b1010;
    push(4'b0010, 7'h02, 2'd1);
    push(4'b1000, 7'h08, 2'd3);
    push(4'b0010, 7'h02, 2'd1);
    push(4'b1000, 7'h08, 2'd3);
    for (int i = 0; i < 4; i++) wait_tick("sparse", 4);

    // Nothing enabled: blank output, index holds, tick keeps running.
    digit_en = 4'b0000;
    push(4'b0000, 7'h00, 2'd3);
    push(4'b0000, 7'h00, 2'd3);
    for (int i = 0; i < 2; i++) wait_tick("none", 4);

    // Load coincident with the tick that selects digit 1.
    digit_en = 4'b1111;
    push(4'b0001, 7'h01, 2'd0);
    push(4'b0010, 7'h02, 2'd1);
    push(4'b0100, 7'h04, 2'd2);
    push(4'b1000, 7'h08, 2'd3);
    push(4'b0001, 7'h01, 2'd0);
    push(4'b0010, 7'h7F, 2'd1);
    wait_tick("ld_d0", 4);
    repeat (3) @(negedge clk);
    load      = 1'b1;
    digits_in = {7'h08, 7'h04, 7'h7F, 7'h01};
    wait_tick("ld_same", 1);
    load = 1'b0;
    for (int i = 0; i < 4; i++) wait_tick("ld_after", 4);

    // Asynchronous reset while sig is high; no clock edge before the checks.
    #1 rst_n = 1'b0;
    #1;
    chk("arst_segment", 32'(segment),   32'h0);
    chk("arst_anode",   32'(anode),     32'h0);
    chk("arst_sig",     32'(sig),       32'h0);
    chk("arst_idx",     32'(digit_idx), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    // Shadow was cleared by reset, so digit 0 shows a blank pattern.
    push(4'b0001, 7'h00, 2'd0);
    wait_tick("arst_first", 4);

`ifdef SEVEN_SEG_BRIGHTNESS_EN
    duty = 4'd7;
    push(4'b0010, 7'h00, 2'd1);
    wait_tick("dim_tick", 4);
    @(negedge clk);
    chk("dim_cnt1", 32'(anode), 32'b0010);
    @(negedge clk);
    chk("dim_cnt2", 32'(anode), 32'b0000);
    @(negedge clk);
    chk("dim_cnt3", 32'(anode), 32'b0000);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
